// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared constants, read-sequencer state codes and the round-robin pointer helper
// used by the fifo_rr_scheduler slice.
package fifo_rr_scheduler_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Pointer that follows grant g, wrapping at n (n is 2..4, so the sum never exceeds 4).
  function automatic logic [1:0] rr_next(input logic [1:0] g, input int n);
    logic [2:0] sum;
    sum = {1'b0, g} + 3'd1;
    if (int'(sum) >= n) begin
      rr_next = 2'd0;
    end else begin
      rr_next = sum[1:0];
    end
  endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// Purely combinational round-robin arbiter: the first requester at or after ptr
// (mod N_REQ) wins while en is high.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [1:0]       gnt_id,
  output logic             gnt_any
);

  localparam logic [2:0] N_LIM = 3'(N_REQ);

  logic [2*N_REQ-1:0] dbl_s;
  logic               hit_s;
  logic [1:0]         off_s;
  logic [2:0]         sum_s;
  logic [2:0]         idx_s;

  // Rotate the request vector so ptr sits at bit 0, then take the first set bit.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    hit_s = 1'b0;
    off_s = 2'd0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!hit_s && dbl_s[k]) begin
        hit_s = 1'b1;
        off_s = 2'(k);
      end else begin
        hit_s = hit_s;
      end
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= N_LIM) begin
      idx_s = sum_s - N_LIM;
    end else begin
      idx_s = sum_s;
    end
  end

  assign gnt_any = en & hit_s;
  assign gnt_id  = gnt_any ? idx_s[1:0] : 2'd0;

  // Expand the winning index into the one-hot accept vector.
  always_comb begin
    gnt_onehot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      gnt_onehot[j] = gnt_any && (gnt_id == 2'(j));
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin write arbitration of N_REQ byte producers into a 16x8 fifo, plus a
// two-state read sequencer that drains the fifo into a registered valid/ready stage.
module fifo_rr_scheduler #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_wr,
  output logic [DATA_W-1:0]       fifo_wdata,
  input  logic                    fifo_full,
  output logic                    fifo_rd,
  input  logic [DATA_W-1:0]       fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [1:0]              grant_id,
  output logic [CNT_W-1:0]        wr_count,
  output logic [CNT_W-1:0]        rd_count
);

  import fifo_rr_scheduler_pkg::*;

  logic [1:0]       rr_ptr_r;
  logic [N_REQ-1:0] gnt_onehot_s;
  logic [1:0]       gnt_id_s;
  logic             gnt_any_s;
  logic             arb_en_s;
  out_state_t       state_r;
  out_state_t       state_nx_s;
  logic             rd_s;
  logic             acc_s;

  // Gating with rst_n keeps the accept strobes low for the whole reset window.
  assign arb_en_s = en & ~fifo_full & rst_n;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr_r),
    .en         (arb_en_s),
    .gnt_onehot (gnt_onehot_s),
    .gnt_id     (gnt_id_s),
    .gnt_any    (gnt_any_s)
  );

  assign req_ready = gnt_onehot_s;
  assign fifo_wr   = gnt_any_s;
  assign grant_id  = gnt_id_s;
  assign out_valid = (state_r == OUT_FULL);
  assign fifo_rd   = rd_s;

  // Route the granted producer's byte onto the fifo write data.
  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_onehot_s[i]) begin
        fifo_wdata = req_data[i*DATA_W +: DATA_W];
      end else begin
        fifo_wdata = fifo_wdata;
      end
    end
  end

  // Read sequencer next state; a pop always coincides with a load of out_data.
  always_comb begin
    state_nx_s = state_r;
    rd_s       = 1'b0;
    acc_s      = 1'b0;
    case (state_r)
      OUT_EMPTY: begin
        if (rst_n && !fifo_empty) begin
          rd_s       = 1'b1;
          state_nx_s = OUT_FULL;
        end else begin
          state_nx_s = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        if (out_ready) begin
          acc_s = 1'b1;
          if (!fifo_empty) begin
            rd_s       = 1'b1;
            state_nx_s = OUT_FULL;
          end else begin
            state_nx_s = OUT_EMPTY;
          end
        end else begin
          state_nx_s = OUT_FULL;
        end
      end
      default: begin
        state_nx_s = OUT_EMPTY;
      end
    endcase
  end

  // Sequencer state, output byte register, rr pointer and transfer counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= OUT_EMPTY;
      out_data <= '0;
      rr_ptr_r <= 2'd0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      state_r <= state_nx_s;
      if (rd_s) begin
        out_data <= fifo_rdata;
      end
      if (gnt_any_s) begin
        rr_ptr_r <= rr_next(gnt_id_s, N_REQ);
        wr_count <= wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (acc_s) begin
        rd_count <= rd_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench for fifo_rr_scheduler with a behavioural 16x8 fifo
// (combinational head, shared async reset).
module tb_fifo_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic        fifo_full;
  logic        fifo_rd;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_rr    = 0;
  logic [7:0] pq0[$];
  logic [7:0] pq1[$];
  logic [7:0] sb[$];

  // Behavioural fifo
  logic [7:0] f_mem[16];
  logic [3:0] f_wp, f_rp;
  logic [4:0] f_cnt;
  assign fifo_full  = (f_cnt == 5'd16);
  assign fifo_empty = (f_cnt == 5'd0);
  assign fifo_rdata = f_mem[f_rp];

  always @(posedge clk) begin
    if (fifo_wr && !fifo_full) f_mem[f_wp] <= fifo_wdata;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_wp <= 4'd0; f_rp <= 4'd0; f_cnt <= 5'd0;
    end else begin
      if (fifo_wr && !fifo_full) f_wp <= f_wp + 4'd1;
      if (fifo_rd && !fifo_empty) f_rp <= f_rp + 4'd1;
      f_cnt <= f_cnt + 5'((fifo_wr && !fifo_full) ? 1 : 0) - 5'((fifo_rd && !fifo_empty) ? 1 : 0);
    end
  end

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.N_REQ(2), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .grant_id(grant_id), .wr_count(wr_count), .rd_count(rd_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_win(input logic [1:0] v, input int ptr, input logic ok);
    int w;
    w = -1;
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        int i;
        i = (ptr + k) % 2;
        if (w < 0 && v[i[0]]) w = i;
      end
    end
    return w;
  endfunction

  task automatic drive();
    req_valid = {pq1.size() != 0, pq0.size() != 0};
    req_data  = {(pq1.size() != 0) ? pq1[0] : 8'h00, (pq0.size() != 0) ? pq0[0] : 8'h00};
  endtask

  // One clock: check arbitration and output at negedge, advance producers after posedge.
  task automatic step();
    int win;
    logic [7:0] exp_b;
    logic [7:0] exp_out;
    @(negedge clk);
    win = exp_win(req_valid, tb_rr, en & ~fifo_full & rst_n);
    check_val("req_ready", req_ready, (win < 0) ? 0 : (1 << win));
    check_val("fifo_wr", fifo_wr, (win >= 0) ? 1 : 0);
    check_val("grant_id", grant_id, (win < 0) ? 0 : win);
    if (win >= 0) begin
      exp_b = (win == 0) ? pq0[0] : pq1[0];
      check_val("fifo_wdata", fifo_wdata, exp_b);
      sb.push_back(exp_b);
    end
    check_val("rd_when_empty", fifo_rd & fifo_empty, 0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 1, 0);
      end else begin
        exp_out = sb.pop_front();
        check_val("out_data", out_data, exp_out);
      end
    end
    @(posedge clk);
    #1;
    if (win == 0) void'(pq0.pop_front());
    else if (win == 1) void'(pq1.pop_front());
    if (win >= 0) tb_rr = (win + 1) % 2;
    drive();
  endtask

  initial begin
    int rem;
    // Test 1: reset with both producers valid
    rst_n = 1'b0; en = 1'b1; out_ready = 1'b0;
    req_valid = 2'b11; req_data = 16'hBBAA;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready", req_ready, 0);
    check_val("rst_fifo_wr", fifo_wr, 0);
    check_val("rst_fifo_rd", fifo_rd, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_grant_id", grant_id, 0);
    check_val("rst_wr_count", wr_count, 0);
    check_val("rst_rd_count", rd_count, 0);
    drive();
    rst_n = 1'b1;

    // Test 2: round-robin fairness, both producers streaming
    for (int i = 0; i < 4; i++) begin
      pq0.push_back(8'hA0 + 8'(i));
      pq1.push_back(8'hB0 + 8'(i));
    end
    out_ready = 1'b1;
    drive();
    repeat (20) step();
    check_val("rr_wr_count", wr_count, 8);
    check_val("rr_rd_count", rd_count, 8);

    // Test 3: full backpressure with stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) pq0.push_back(8'(i));
    drive();
    repeat (40) step();
    check_val("full_flag", fifo_full, 1);
    check_val("full_pending", pq0.size(), 3);
    check_val("full_wr_count", wr_count, 25);
    check_val("full_out_valid", out_valid, 1);
    check_val("full_out_data", out_data, 8'h00);
    out_ready = 1'b1;
    repeat (40) step();
    check_val("full_drain_rd", rd_count, 28);

    // Test 4: en=0 blocks, then output stall
    en = 1'b0; out_ready = 1'b0;
    pq0.push_back(8'h11); pq0.push_back(8'h22); pq0.push_back(8'h33);
    drive();
    repeat (3) step();
    check_val("en_off_wr_count", wr_count, 28);
    en = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("stall_valid", out_valid, 1);
      check_val("stall_data", out_data, 8'h11);
      check_val("stall_rd", fifo_rd, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("b2b_valid", out_valid, 1);
      step();
    end
    check_val("stall_rd_count", rd_count, 31);

    // Test 5: simultaneous push and pop with one byte in the fifo
    out_ready = 1'b0;
    pq0.push_back(8'h44); pq0.push_back(8'h55);
    drive();
    repeat (6) step();
    check_val("sim_pre_cnt", f_cnt, 1);
    pq1.push_back(8'h66);
    out_ready = 1'b1;
    drive();
    #2;
    check_val("sim_wr", fifo_wr, 1);
    check_val("sim_rd", fifo_rd, 1);
    step();
    check_val("sim_cnt", f_cnt, 1);
    check_val("sim_empty", fifo_empty, 0);
    check_val("sim_full", fifo_full, 0);
    check_val("sim_out_data", out_data, 8'h55);
    repeat (6) step();
    check_val("sim_wr_count", wr_count, 34);
    check_val("sim_rd_count", rd_count, 34);

    // Test 6: async reset in the middle of a round-robin stream
    for (int i = 0; i < 8; i++) begin
      pq0.push_back(8'hC0 + 8'(i));
      pq1.push_back(8'hD0 + 8'(i));
    end
    drive();
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_req_ready", req_ready, 0);
    check_val("ar_fifo_wr", fifo_wr, 0);
    check_val("ar_out_valid", out_valid, 0);
    check_val("ar_wr_count", wr_count, 0);
    check_val("ar_rd_count", rd_count, 0);
    sb.delete();
    tb_rr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
    rem = pq0.size() + pq1.size();
    repeat (30) step();
    check_val("ar_post_wr_count", wr_count, rem);
    check_val("ar_post_rd_count", rd_count, rem);
    check_val("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
